// File: rtl/cache_pkg.sv
// Shared cache geometry and the refill controller state encoding.
package cache_pkg;
   localparam int TAG_W  = 28;
   localparam int IDX_W  = 2;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_FILL
   } refill_state_t;
endpackage

// File: rtl/cache_refill_ctrl.sv
// Single-word cache miss refill: accept miss, request memory, wait with timeout,
// then strobe one fill/response cycle.
module cache_refill_ctrl
   import cache_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int MISS_CNT_W     = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  miss_valid,
   input  logic [ADDR_W-1:0]     miss_addr,
   output logic                  miss_ready,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [ADDR_W-1:0]     mem_req_addr,
   input  logic                  mem_rsp_valid,
   input  logic [DATA_W-1:0]     mem_rsp_data,
   output logic                  fill_we,
   output logic [IDX_W-1:0]      fill_index,
   output logic [TAG_W-1:0]      fill_tag,
   output logic [DATA_W-1:0]     fill_data,
   output logic                  resp_valid,
   output logic                  err_timeout,
   output logic [MISS_CNT_W-1:0] miss_count
);
   localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

   refill_state_t          state_reg, state_next;
   logic [ADDR_W-1:2]      addr_reg;
   logic [DATA_W-1:0]      data_reg;
   logic [TIMER_W-1:0]     timer_reg;
   logic [MISS_CNT_W-1:0]  count_reg;
   logic                   err_reg;
   logic                   capture_miss;
   logic                   capture_rsp;
   logic                   timeout_hit;
   logic                   unused_addr_lsbs;

   // Byte offset within the word never reaches memory or the arrays.
   assign unused_addr_lsbs = ^miss_addr[1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      capture_miss  = 1'b0;
      capture_rsp   = 1'b0;
      timeout_hit   = 1'b0;
      miss_ready    = 1'b0;
      mem_req_valid = 1'b0;
      fill_we       = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            // Gate with reset so nothing is offered while reset is held.
            miss_ready = !reset;
            if (miss_valid) begin
               capture_miss = 1'b1;
               state_next   = ST_REQ;
            end
         end
         ST_REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) begin
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // A response arriving on the last timer cycle still wins.
            if (mem_rsp_valid) begin
               capture_rsp = 1'b1;
               state_next  = ST_FILL;
            end else if (timer_reg == TIMER_LAST) begin
               timeout_hit = 1'b1;
               state_next  = ST_IDLE;
            end
         end
         ST_FILL: begin
            fill_we    = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_reg  <= '0;
         data_reg  <= '0;
         timer_reg <= '0;
         count_reg <= '0;
         err_reg   <= 1'b0;
      end else begin
         err_reg <= timeout_hit;
         if (capture_miss) begin
            addr_reg <= miss_addr[ADDR_W-1:2];
            if (count_reg != {MISS_CNT_W{1'b1}}) begin
               count_reg <= count_reg + 1'b1;
            end
         end
         if (capture_rsp) begin
            data_reg <= mem_rsp_data;
         end
         // Held at zero outside WAIT, so every WAIT entry starts from zero.
         if (state_reg == ST_WAIT) begin
            timer_reg <= timer_reg + 1'b1;
         end else begin
            timer_reg <= '0;
         end
      end
   end

   assign mem_req_addr = {addr_reg, 2'b00};
   assign fill_index   = addr_reg[2 +: IDX_W];
   assign fill_tag     = addr_reg[ADDR_W-1 -: TAG_W];
   assign fill_data    = data_reg;
   assign resp_valid   = fill_we;
   assign err_timeout  = err_reg;
   assign miss_count   = count_reg;
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomized bench for cache_refill_ctrl; expected timing derived from the
// transaction's request delay and response delay.
module tb_cache_refill_ctrl;
   localparam int TO      = 64;
   localparam int CW      = 2;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clk;
   logic          reset;
   logic          miss_valid;
   logic [31:0]   miss_addr;
   logic          miss_ready;
   logic          mem_req_valid;
   logic          mem_req_ready;
   logic [31:0]   mem_req_addr;
   logic          mem_rsp_valid;
   logic [31:0]   mem_rsp_data;
   logic          fill_we;
   logic [1:0]    fill_index;
   logic [27:0]   fill_tag;
   logic [31:0]   fill_data;
   logic          resp_valid;
   logic          err_timeout;
   logic [CW-1:0] miss_count;

   int total = 0;
   int bad = 0;
   int model_count = 0;

   cache_refill_ctrl #(
      .TIMEOUT_CYCLES(TO),
      .MISS_CNT_W(CW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .miss_valid(miss_valid),
      .miss_addr(miss_addr),
      .miss_ready(miss_ready),
      .mem_req_valid(mem_req_valid),
      .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr),
      .mem_rsp_valid(mem_rsp_valid),
      .mem_rsp_data(mem_rsp_data),
      .fill_we(fill_we),
      .fill_index(fill_index),
      .fill_tag(fill_tag),
      .fill_data(fill_data),
      .resp_valid(resp_valid),
      .err_timeout(err_timeout),
      .miss_count(miss_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Starts at a negedge with the DUT idle (cycle 0 = accept cycle).
   // d = REQ cycles with ready low, r = WAIT cycles before the response.
   task automatic run_miss(input logic [31:0] addr, input int d, input int r,
                           input logic [31:0] data, input bit hold,
                           input logic [31:0] next_addr);
      bit in_time;
      int fill_cyc, err_cyc, end_cyc, wait_last;
      logic exp_req, exp_fill, exp_err, exp_ready;
      logic [31:0] exp_addr;
      exp_addr  = {addr[31:2], 2'b00};
      in_time   = (r < TO);
      fill_cyc  = 3 + d + r;
      err_cyc   = 2 + d + TO;
      end_cyc   = in_time ? fill_cyc + 1 : err_cyc;
      wait_last = in_time ? 2 + d + r : 1 + d + TO;
      total++;
      if (miss_ready !== 1'b1) begin
         bad++;
         $display("FAIL accept_ready: miss_ready=%b expected 1", miss_ready);
      end
      miss_valid = 1'b1;
      miss_addr  = addr;
      model_count = (model_count < CNT_MAX) ? model_count + 1 : CNT_MAX;
      for (int cyc = 1; cyc <= end_cyc; cyc++) begin
         @(negedge clk);
         exp_req   = (cyc <= 1 + d);
         exp_fill  = in_time && (cyc == fill_cyc);
         exp_err   = !in_time && (cyc == err_cyc);
         exp_ready = (cyc == end_cyc);
         total++;
         if (mem_req_valid !== exp_req) begin
            bad++;
            $display("FAIL req_valid cyc=%0d: got %b expected %b", cyc, mem_req_valid, exp_req);
         end
         total++;
         if (fill_we !== exp_fill) begin
            bad++;
            $display("FAIL fill_we cyc=%0d: got %b expected %b", cyc, fill_we, exp_fill);
         end
         total++;
         if (err_timeout !== exp_err) begin
            bad++;
            $display("FAIL err_timeout cyc=%0d: got %b expected %b", cyc, err_timeout, exp_err);
         end
         total++;
         if (miss_ready !== exp_ready) begin
            bad++;
            $display("FAIL miss_ready cyc=%0d: got %b expected %b", cyc, miss_ready, exp_ready);
         end
         if (exp_req) begin
            total++;
            if (mem_req_addr !== exp_addr) begin
               bad++;
               $display("FAIL req_addr cyc=%0d: got %h expected %h", cyc, mem_req_addr, exp_addr);
            end
         end
         if (exp_fill) begin
            total++;
            if (resp_valid !== 1'b1 || fill_data !== data || fill_index !== addr[3:2]
                || fill_tag !== addr[31:4]) begin
               bad++;
               $display("FAIL fill_payload: rv=%b idx=%0d tag=%h data=%h expected rv=1 idx=%0d tag=%h data=%h",
                        resp_valid, fill_index, fill_tag, fill_data, addr[3:2], addr[31:4], data);
            end
         end
         if (cyc == 1) begin
            total++;
            if (miss_count !== CW'(model_count)) begin
               bad++;
               $display("FAIL miss_count: got %0d expected %0d", miss_count, model_count);
            end
         end
         miss_valid    = hold;
         miss_addr     = hold ? next_addr : 32'($urandom);
         mem_req_ready = (cyc == 1 + d) ? 1'b1 : ((cyc > 1 + d) ? 1'($urandom_range(0, 1)) : 1'b0);
         if (in_time && cyc == 2 + d + r) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = data;
         end else if (cyc <= 1 + d || cyc > wait_last) begin
            mem_rsp_valid = 1'($urandom_range(0, 1));
            mem_rsp_data  = 32'($urandom);
         end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = 32'($urandom);
         end
      end
      $display("txn addr=%h d=%0d r=%0d hold=%0d %s count=%0d", addr, d, r, hold,
               in_time ? "fill" : "timeout", model_count);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      miss_valid = 1'b0;
      mem_rsp_valid = 1'b0;
      model_count = 0;
      #1;
   endtask

   task automatic check_outputs_zero(input string tag);
      total++;
      if (miss_ready !== 1'b0 || mem_req_valid !== 1'b0 || fill_we !== 1'b0 || resp_valid !== 1'b0
          || err_timeout !== 1'b0 || mem_req_addr !== 32'h0 || fill_index !== 2'h0
          || fill_tag !== 28'h0 || fill_data !== 32'h0 || miss_count !== '0) begin
         bad++;
         $display("FAIL %s: rdy=%b rv=%b we=%b resp=%b err=%b addr=%h idx=%0d tag=%h data=%h cnt=%0d expected all 0",
                  tag, miss_ready, mem_req_valid, fill_we, resp_valid, err_timeout, mem_req_addr,
                  fill_index, fill_tag, fill_data, miss_count);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      miss_valid = 1'b1;
      miss_addr = 32'hFFFF_FFFF;
      mem_req_ready = 1'b1;
      mem_rsp_valid = 1'b1;
      mem_rsp_data = 32'hFFFF_FFFF;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset_state");
      miss_valid = 1'b0;
      mem_rsp_valid = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      total++;
      if (miss_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_release_ready: got %b expected 1", miss_ready);
      end
      $display("test_reset done");
   endtask

   task automatic test_single_miss();
      run_miss(32'hF9A7C1F0, 0, 0, 32'hDEADBEEF, 1'b0, 32'h0);
   endtask

   task automatic test_req_stall();
      run_miss(32'h1234_567C, 10, 3, 32'hA5A5_0F0F, 1'b0, 32'h0);
   endtask

   task automatic test_timeout();
      run_miss(32'h0BAD_F00D, 1, TO, 32'h0, 1'b0, 32'h0);
      run_miss(32'h7777_0008, 0, TO - 1, 32'hCAFE_F00D, 1'b0, 32'h0);
      run_miss(32'h3000_0004, 2, TO + 20, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic test_reset_midmiss();
      miss_valid = 1'b1;
      miss_addr = 32'h89AB_CDEC;
      @(negedge clk);
      miss_valid = 1'b0;
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      @(negedge clk);
      #2 reset = 1'b1;
      #1 check_outputs_zero("reset_in_wait");
      @(negedge clk);
      reset = 1'b0;
      model_count = 0;
      for (int i = 0; i < 4; i++) begin
         mem_rsp_valid = (i < 3);
         mem_rsp_data = 32'h5555_AAAA;
         @(negedge clk);
         total++;
         if (fill_we !== 1'b0 || err_timeout !== 1'b0 || miss_ready !== 1'b1 || miss_count !== '0) begin
            bad++;
            $display("FAIL post_reset_rsp i=%0d: we=%b err=%b rdy=%b cnt=%0d expected 0 0 1 0",
                     i, fill_we, err_timeout, miss_ready, miss_count);
         end
      end
      $display("test_reset_midmiss done");
   endtask

   task automatic test_back_to_back();
      logic [31:0] addrs [5];
      do_reset();
      for (int i = 0; i < 5; i++) addrs[i] = 32'($urandom);
      for (int i = 0; i < 5; i++) begin
         run_miss(addrs[i], i % 2, i, 32'($urandom), (i < 4), (i < 4) ? addrs[(i + 1) % 5] : 32'h0);
      end
   endtask

   task automatic test_random();
      logic [31:0] cur, nxt;
      int d, r, sel;
      bit hold;
      do_reset();
      cur = 32'($urandom);
      for (int i = 0; i < 25; i++) begin
         nxt  = 32'($urandom);
         d    = $urandom_range(0, 4);
         sel  = $urandom_range(0, 9);
         r    = (sel == 0) ? TO - 1 : (sel == 1) ? TO : $urandom_range(0, 8);
         hold = (i < 24) ? 1'($urandom_range(0, 1)) : 1'b0;
         run_miss(cur, d, r, 32'($urandom), hold, nxt);
         cur = nxt;
         if (!hold) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_miss();
      test_req_stall();
      test_timeout();
      test_reset_midmiss();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
